// File: rtl/de10nano_input_cond_if.sv
// Board-input bundle between the raw DE10-Nano pins, the conditioning stage
// and the PIO block it feeds.
interface de10nano_input_cond_if;
    logic [3:0] sw_raw;
    logic [1:0] key_raw;
    logic [3:0] sw_db;
    logic [1:0] key_db;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [3:0] sw_change;

    // Board side: drives the raw pins, consumes the conditioned levels/pulses.
    modport master (
        output sw_raw, key_raw,
        input  sw_db, key_db, key_press, key_release, sw_change
    );

    // Conditioning stage side.
    modport slave (
        input  sw_raw, key_raw,
        output sw_db, key_db, key_press, key_release, sw_change
    );
endinterface

// File: rtl/de10nano_input_cond.sv
// Input conditioning for DE10-Nano switches and keys: 2-flop synchronizer,
// per-bit stability-counter debounce, active-high key levels and registered
// one-cycle edge pulses.

// One conditioning channel: synchronizer, debounce counter, edge pulses.
module de10nano_input_cond_chan #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1, s2;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer; s1 feeds s2 directly with no logic between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Stability counter: any return to db restarts the count from zero;
    // reaching LAST commits the new level, so the counter never wraps.
    // Pulses are registered so they line up with the first cycle of new db.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db   <= 1'b0;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                db   <= s2;
                cnt  <= '0;
                rise <= s2;
                fall <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module de10nano_input_cond #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    de10nano_input_cond_if.slave  io
);
    localparam int NUM_SW  = 4;
    localparam int NUM_KEY = 2;
    localparam int NUM_CH  = NUM_SW + NUM_KEY;

    // Channels [3:0] are switches, [5:4] are keys inverted to active-high
    // ahead of the synchronizer so all downstream state is "1 = pressed".
    logic [NUM_CH-1:0] raw, db, rise, fall;

    assign raw = {~io.key_raw, io.sw_raw};

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            de10nano_input_cond_chan #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_chan (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (raw[g]),
                .db    (db[g]),
                .rise  (rise[g]),
                .fall  (fall[g])
            );
        end
    endgenerate

    assign io.sw_db       = db[NUM_SW-1:0];
    assign io.key_db      = db[NUM_CH-1:NUM_SW];
    assign io.key_press   = rise[NUM_CH-1:NUM_SW];
    assign io.key_release = fall[NUM_CH-1:NUM_SW];
    // rise/fall are mutually exclusive flops, so the OR is a clean pulse
    // with no path back to the raw pins.
    assign io.sw_change   = rise[NUM_SW-1:0] | fall[NUM_SW-1:0];
endmodule

// File: tb/tb_de10nano_input_cond.sv
module tb_de10nano_input_cond;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    int   n_swc [4];
    int   n_kp  [2];
    int   n_kr  [2];
    int   n_both;
    int   drops;

    de10nano_input_cond_if bus ();

    de10nano_input_cond #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 4; i++) n_swc[i] = 0;
        for (int i = 0; i < 2; i++) begin n_kp[i] = 0; n_kr[i] = 0; end
        n_both = 0;
        drops  = 0;
    endtask

    // Advance one edge, then sample 1 time unit later and tally pulses.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) if (bus.sw_change[i] === 1'b1) n_swc[i]++;
            for (int i = 0; i < 2; i++) begin
                if (bus.key_press[i] === 1'b1)   n_kp[i]++;
                if (bus.key_release[i] === 1'b1) n_kr[i]++;
                if (bus.key_press[i] === 1'b1 && bus.key_release[i] === 1'b1) n_both++;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.sw_raw  = 4'b0000;
        bus.key_raw = 2'b11;
        clr_counts();

        // Reset state
        step(2);
        check("rst_sw_db",   32'(bus.sw_db), 0);
        check("rst_key_db",  32'(bus.key_db), 0);
        check("rst_pulses",  32'({bus.sw_change, bus.key_press, bus.key_release}), 0);
        rst_n = 1'b1;
        step(20);
        check("idle_levels", 32'({bus.sw_db, bus.key_db}), 0);
        check("idle_pulses", 32'(n_swc[0] + n_swc[1] + n_swc[2] + n_swc[3] + n_kp[0] + n_kp[1] + n_kr[0] + n_kr[1]), 0);

        // Clean press / release on key 0
        clr_counts();
        bus.key_raw = 2'b10;
        step(5);
        check("press_early", 32'(bus.key_db), 0);
        step(1);
        check("press_db",    32'(bus.key_db), 32'h1);
        check("press_pulse", 32'(bus.key_press), 32'h1);
        step(1);
        check("press_1cyc",  32'(bus.key_press), 0);
        bus.key_raw = 2'b11;
        step(5);
        check("rel_early",   32'(bus.key_db), 32'h1);
        step(1);
        check("rel_db",      32'(bus.key_db), 0);
        check("rel_pulse",   32'(bus.key_release), 32'h1);
        step(1);
        check("rel_1cyc",    32'(bus.key_release), 0);
        check("press_count", 32'(n_kp[0]), 1);
        check("rel_count",   32'(n_kr[0]), 1);

        // Bounce rejection on switch 2
        do_reset();
        clr_counts();
        for (int r = 0; r < 5; r++) begin
            bus.sw_raw[2] = 1'b1;
            step(3);
            bus.sw_raw[2] = 1'b0;
            step(1);
        end
        check("bounce_quiet", 32'(bus.sw_db), 0);
        bus.sw_raw[2] = 1'b1;
        step(5);
        check("bounce_early", 32'(bus.sw_db), 0);
        step(1);
        check("bounce_db",    32'(bus.sw_db), 32'h4);
        step(4);
        check("bounce_count", 32'(n_swc[2]), 1);

        // Simultaneous channels
        bus.sw_raw  = 4'b0000;
        bus.key_raw = 2'b11;
        do_reset();
        clr_counts();
        bus.sw_raw  = 4'b1010;
        bus.key_raw = 2'b00;
        step(5);
        check("sim_early", 32'({bus.sw_db, bus.key_db}), 0);
        step(1);
        check("sim_sw_db",  32'(bus.sw_db), 32'ha);
        check("sim_key_db", 32'(bus.key_db), 32'h3);
        check("sim_swc",    32'(bus.sw_change), 32'ha);
        check("sim_kp",     32'(bus.key_press), 32'h3);
        step(1);
        check("sim_1cyc",   32'({bus.sw_change, bus.key_press}), 0);

        // Reset mid-count on switch 0
        bus.sw_raw  = 4'b0000;
        bus.key_raw = 2'b11;
        do_reset();
        clr_counts();
        bus.sw_raw = 4'b0001;
        step(4);
        rst_n = 1'b0;
        step(1);
        check("midrst_db", 32'(bus.sw_db), 0);
        rst_n = 1'b1;
        step(5);
        check("midrst_early", 32'(bus.sw_db), 0);
        check("midrst_nopls", 32'(n_swc[0]), 0);
        step(1);
        check("midrst_db_up", 32'(bus.sw_db), 32'h1);
        step(3);
        check("midrst_count", 32'(n_swc[0]), 1);

        // Counter saturation on key 1
        bus.sw_raw = 4'b0000;
        do_reset();
        clr_counts();
        bus.key_raw = 2'b01;
        step(6);
        check("sat_db", 32'(bus.key_db), 32'h2);
        for (int c = 0; c < 994; c++) begin
            step(1);
            if (bus.key_db[1] !== 1'b1) drops++;
        end
        check("sat_press", 32'(n_kp[1]), 1);
        check("sat_rel",   32'(n_kr[1]), 0);
        check("sat_hold",  32'(drops), 0);
        check("excl",      32'(n_both), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/de10nano_input_cond.md
# de10nano_input_cond

Input conditioning stage for the DE10-Nano board inputs. It sits directly upstream of the board PIO block and feeds its `SW` and `KEY` inputs. It takes the raw asynchronous slide-switch and push-button pins and performs three steps on them:
- synchronizes them to `clk`,
- debounces each bit with a per-bit stability counter,
- converts the active-low keys to active-high pressed levels.

It also produces single-cycle press/release/change pulses for event-driven logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive cycles a synchronized input must differ from its debounced value before the debounced value is updated. Legal range ≥1; 50000 = 1 ms at 50 MHz.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: per-bit counter width. Derived; not to be overridden.

Ports:
- `clk`  input  1  system clock; all state on the rising edge
- `rst_n`  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- `sw_raw`  input  4  raw slide-switch pins, asynchronous, 1 = on
- `key_raw`  input  2  raw push-button pins, asynchronous, active-low (0 = pressed)
- `sw_db`  output  4  debounced switch levels, 1 = on; connects to PIO `SW`
- `key_db`  output  2  debounced key levels, active-high (1 = pressed); connects to PIO `KEY`
- `key_press`  output  2  one-cycle pulse per bit when `key_db` rises
- `key_release`  output  2  one-cycle pulse per bit when `key_db` falls
- `sw_change`  output  4  one-cycle pulse per bit when `sw_db` toggles

## Operation
- Six independent channels: 4 switch bits and 2 key bits. Every channel has identical logic.
- Key channels invert the raw pin (`~key_raw`) before the synchronizer. All internal key state is active-high.
- Synchronizer: two flip-flops per channel (`s1`, `s2`). Only `s2` is used downstream. No logic sits between `s1` and `s2`.
- Per-channel state: debounced level `db`, counter `cnt` (`CNT_W` bits).
- Each cycle, per channel:
  - `s2 == db`: `cnt <= 0`.
  - `s2 != db` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `s2 != db` and `cnt == DEBOUNCE_CYCLES-1`: `db <= s2`, `cnt <= 0`, and the channel's pulse output is registered high for the following cycle.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles resets `cnt` to 0 when `s2` returns to `db`. No partial credit carries over; `db` does not change.
- The counter never wraps: it saturates at `DEBOUNCE_CYCLES-1` and resolves on the same edge.
- Pulses:
  - `key_press[i]` = `db` went 0→1.
  - `key_release[i]` = `db` went 1→0.
  - `sw_change[i]` = `db` toggled in either direction.
  - Every pulse is exactly one cycle and is registered, aligned with the cycle in which the new `db` is first visible.
  - `key_press` and `key_release` are never high together for the same bit.
- Channels are fully independent. Simultaneous transitions on several bits resolve independently and may pulse in the same cycle.

## Timing
- Reset values (asserted asynchronously, held while `rst_n`=0):
  - all `s1`/`s2` = 0, so keys read as released;
  - `db` = 0;
  - `cnt` = 0;
  - `sw_db`=4'b0, `key_db`=2'b0, all pulse outputs 0.
- After `rst_n` deasserts, a switch held on at power-up appears on `sw_db` after 2+`DEBOUNCE_CYCLES` edges and produces one `sw_change` pulse. This is intended.
- Latency: if `sw_raw[i]` changes and is stable before rising edge E0:
  - `s2` reflects it after edge E1;
  - `sw_db[i]` and the pulse go high after edge E1+`DEBOUNCE_CYCLES`.
  - Total: `DEBOUNCE_CYCLES`+2 edges from the first sampling edge.
- Pulse width is exactly 1 clock. Minimum spacing between two `db` transitions on one bit is `DEBOUNCE_CYCLES` cycles.
- Reset mid-count: `cnt` is cleared, `db` returns to 0, and any pending pulse is dropped. No pulse is emitted by the reset itself.
- All outputs come directly from flops: no combinational path from raw pins to outputs.

## Test plan
Use `DEBOUNCE_CYCLES`=4 in simulation.
- Reset: assert `rst_n`=0 with `key_raw`=2'b11, `sw_raw`=4'b0 → all outputs 0. Release reset and hold inputs for 20 cycles → outputs stay 0, no pulses.
- Clean press: drive `key_raw[0]` 1→0 and hold → `key_db[0]`=1 exactly 6 edges after the first sampling edge, with `key_press[0]`=1 for one cycle in that same cycle. Then drive `key_raw[0]`→1 → `key_db[0]`=0 6 edges later, with a one-cycle `key_release[0]` pulse.
- Bounce rejection: toggle `sw_raw[2]` 0→1 for 3 cycles, back to 0 for 1 cycle, repeated 5 times, then hold 1 → `sw_db[2]` rises only 6 edges after the final transition; exactly one `sw_change[2]` pulse over the whole sequence.
- Simultaneous channels: change `sw_raw`=4'b1010 and `key_raw`=2'b00 on the same edge → `sw_db`=4'b1010 and `key_db`=2'b11 update in the same cycle; `sw_change`=4'b1010 and `key_press`=2'b11 for one cycle.
- Reset mid-count: hold `sw_raw[0]`=1 for 4 cycles, then pulse `rst_n` low for 1 cycle → no `sw_change[0]` pulse, `sw_db[0]`=0 through reset. After release, `sw_db[0]` rises 6 edges later with one pulse.
- Counter saturation: hold `key_raw[1]`=0 for 1000 cycles → exactly one `key_press[1]` pulse, `key_db[1]` stays 1, no further pulses.
